console_writer: RTL and testbench

Text-console sequencer that owns the write side of the 80x30 character framebuffer. The display scanout reads the same framebuffer on its own read port.
- Accepts a byte stream over a valid/ready handshake and maintains the cursor.
- Interprets control codes and writes glyph codes into framebuffer memory.
- Performs hardware clear-screen and scroll-up by copying framebuffer rows through a pipelined read/write port.

---
 rtl/console_writer_pkg.sv | 34 +++
 rtl/console_writer.sv | 171 +++++++++++++++++
 tb/tb_console_writer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/console_writer_pkg.sv
// Shared definitions for the text console: geometry defaults, control codes,
// sequencer state encoding and the row-address helper used by writer and scanout.
package console_writer_pkg;

  localparam int         DEFAULT_COLS  = 80;
  localparam int         DEFAULT_ROWS  = 30;
  localparam logic [7:0] DEFAULT_BLANK = 8'h20;

  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_FF = 8'h0C;

  typedef enum logic [2:0] {
    ST_CLEAR      = 3'd0,
    ST_IDLE       = 3'd1,
    ST_EXEC       = 3'd2,
    ST_SCROLL     = 3'd3,
    ST_CLEAR_LINE = 3'd4
  } state_t;

  // Any byte that is not one of the four control codes lands in the framebuffer.
  function automatic logic is_glyph(input logic [7:0] b);
    return !((b == CC_LF) || (b == CC_CR) || (b == CC_BS) || (b == CC_FF));
  endfunction

  // y*80 without a multiplier: y*64 + y*16.
  function automatic logic [11:0] row_base_80(input logic [4:0] y);
    logic [11:0] y12;
    y12 = {7'd0, y};
    return (y12 << 6) + (y12 << 4);
  endfunction

endpackage

// File: rtl/console_writer.sv
// Write-side sequencer of the character framebuffer: cursor tracking, control
// codes, hardware clear and scroll-up through a pipelined read/write copy.
module console_writer
  import console_writer_pkg::*;
#(
  parameter int         COLS  = DEFAULT_COLS,
  parameter int         ROWS  = DEFAULT_ROWS,
  parameter logic [7:0] BLANK = DEFAULT_BLANK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [11:0] fb_raddr,
  input  logic [7:0]  fb_rdata,
  output logic [11:0] fb_waddr,
  output logic [7:0]  fb_wdata,
  output logic        fb_we,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam logic [11:0] COLS_W        = 12'(COLS);
  localparam logic [11:0] LAST_ADDR     = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LAST_ROW_ADDR = 12'((ROWS - 1) * COLS);
  localparam logic [6:0]  X_LAST        = 7'(COLS - 1);
  localparam logic [4:0]  Y_LAST        = 5'(ROWS - 1);

  state_t      state_reg;
  logic [11:0] cnt_reg;
  logic [7:0]  cmd_reg;
  logic [7:0]  wdata_reg;
  logic        copy_sel_reg;
  logic        copy_rd_reg;

  logic [11:0] row_addr;
  logic [11:0] cur_addr;
  logic        line_end;

  generate
    if (COLS == 80) begin : g_row80
      assign row_addr = row_base_80(cursor_y);
    end else begin : g_rown
      assign row_addr = 12'(cursor_y * COLS);
    end
  endgenerate

  assign cur_addr = row_addr + {5'd0, cursor_x};
  assign line_end = (cmd_reg == CC_LF) || (is_glyph(cmd_reg) && (cursor_x == X_LAST));

  // Copy writes forward the RAM read data straight through so that a row byte
  // read in cycle k is written back in cycle k+1; the select itself is a register.
  assign fb_wdata = copy_sel_reg ? fb_rdata : wdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_CLEAR;
      cnt_reg      <= '0;
      cmd_reg      <= '0;
      wdata_reg    <= BLANK;
      copy_sel_reg <= 1'b0;
      copy_rd_reg  <= 1'b0;
      cursor_x     <= '0;
      cursor_y     <= '0;
      fb_we        <= 1'b0;
      fb_waddr     <= '0;
      fb_raddr     <= '0;
      char_ready   <= 1'b0;
      busy         <= 1'b1;
    end else begin
      case (state_reg)
        ST_CLEAR, ST_CLEAR_LINE: begin
          fb_we        <= 1'b1;
          fb_waddr     <= cnt_reg;
          wdata_reg    <= BLANK;
          copy_sel_reg <= 1'b0;
          if (cnt_reg == LAST_ADDR) begin
            // char_ready follows one cycle later, from IDLE.
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            cursor_x  <= '0;
            cursor_y  <= (state_reg == ST_CLEAR) ? 5'd0 : Y_LAST;
          end else begin
            cnt_reg <= cnt_reg + 12'd1;
          end
        end

        ST_IDLE: begin
          fb_we      <= 1'b0;
          char_ready <= 1'b1;
          busy       <= 1'b0;
          if (char_valid && char_ready) begin
            cmd_reg    <= char_data;
            char_ready <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= ST_EXEC;
            // The framebuffer write is issued now so it is visible during EXEC.
            if (is_glyph(char_data)) begin
              fb_we     <= 1'b1;
              fb_waddr  <= cur_addr;
              wdata_reg <= char_data;
            end else if ((char_data == CC_BS) && (cursor_x != 7'd0)) begin
              fb_we     <= 1'b1;
              fb_waddr  <= cur_addr - 12'd1;
              wdata_reg <= BLANK;
            end
          end
        end

        ST_EXEC: begin
          fb_we      <= 1'b0;
          char_ready <= 1'b1;
          busy       <= 1'b0;
          state_reg  <= ST_IDLE;
          if (cmd_reg == CC_FF) begin
            state_reg  <= ST_CLEAR;
            cnt_reg    <= '0;
            char_ready <= 1'b0;
            busy       <= 1'b1;
          end else if (line_end) begin
            cursor_x <= '0;
            if (cursor_y != Y_LAST) begin
              cursor_y <= cursor_y + 5'd1;
            end else begin
              state_reg   <= ST_SCROLL;
              fb_raddr    <= COLS_W;
              copy_rd_reg <= 1'b1;
              char_ready  <= 1'b0;
              busy        <= 1'b1;
            end
          end else if (cmd_reg == CC_CR) begin
            cursor_x <= '0;
          end else if (cmd_reg == CC_BS) begin
            if (cursor_x != 7'd0) begin
              cursor_x <= cursor_x - 7'd1;
            end
          end else begin
            cursor_x <= cursor_x + 7'd1;
          end
        end

        ST_SCROLL: begin
          if (copy_rd_reg) begin
            fb_we        <= 1'b1;
            fb_waddr     <= fb_raddr - COLS_W;
            copy_sel_reg <= 1'b1;
            if (fb_raddr == LAST_ADDR) begin
              copy_rd_reg <= 1'b0;
            end else begin
              fb_raddr <= fb_raddr + 12'd1;
            end
          end else begin
            fb_we        <= 1'b0;
            copy_sel_reg <= 1'b0;
            state_reg    <= ST_CLEAR_LINE;
            cnt_reg      <= LAST_ROW_ADDR;
          end
        end

        default: begin
          state_reg <= ST_CLEAR;
          cnt_reg   <= '0;
          fb_we     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// Self-checking bench for console_writer: directed cases plus a random byte
// stream, checked against a character-grid reference model and a RAM model.
module tb_console_writer;

  localparam int CELLS   = 2400;
  localparam int K_NORM  = 0;
  localparam int K_SCROLL = 1;
  localparam int K_CLEAR = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char_data = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [11:0] fb_raddr;
  logic [7:0]  fb_rdata;
  logic [11:0] fb_waddr;
  logic [7:0]  fb_wdata;
  logic        fb_we;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  logic [7:0] mem  [0:CELLS-1];
  logic [7:0] grid [0:CELLS-1];
  int mx = 0;
  int my = 0;
  int n_err = 0;
  int n_chk = 0;
  int last_exec_addr = 0;

  console_writer dut (
    .clk(clk), .reset(reset), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .fb_raddr(fb_raddr), .fb_rdata(fb_rdata),
    .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_we(fb_we),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (fb_we && fb_waddr < CELLS) mem[fb_waddr] <= fb_wdata;
    if (fb_raddr < CELLS) fb_rdata <= mem[fb_raddr];
    else fb_rdata <= 8'hxx;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  endtask

  function automatic logic [7:0] rand_glyph();
    return 8'($urandom_range(33, 126));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) grid[i] = 8'h20;
    mx = 0;
    my = 0;
  endtask

  task automatic model_newline(inout int kind);
    mx = 0;
    if (my < 29) my++;
    else begin
      for (int i = 0; i < CELLS - 80; i++) grid[i] = grid[i + 80];
      for (int i = CELLS - 80; i < CELLS; i++) grid[i] = 8'h20;
      kind = K_SCROLL;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int kind);
    int n;
    logic exp_we;
    int exp_addr;
    logic [7:0] exp_data;
    n = 0;
    while (char_ready !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (char_ready !== 1'b1) begin
      check("ready_timeout", 32'd0, 32'd1);
      finish_run();
    end
    check("idle_busy", busy, 0);
    char_data = b;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_data = 8'($urandom);
    exp_we = 1'b0;
    exp_addr = 0;
    exp_data = 8'h00;
    kind = K_NORM;
    case (b)
      8'h0A: model_newline(kind);
      8'h0D: mx = 0;
      8'h08: if (mx > 0) begin
        mx--;
        exp_we = 1'b1;
        exp_addr = my * 80 + mx;
        exp_data = 8'h20;
        grid[exp_addr] = 8'h20;
      end
      8'h0C: begin
        model_clear();
        kind = K_CLEAR;
      end
      default: begin
        exp_we = 1'b1;
        exp_addr = my * 80 + mx;
        exp_data = b;
        grid[exp_addr] = b;
        if (mx < 79) mx++;
        else model_newline(kind);
      end
    endcase
    check("exec_ready", char_ready, 0);
    check("exec_we", fb_we, exp_we);
    if (exp_we) begin
      check("exec_addr", fb_waddr, exp_addr);
      check("exec_data", fb_wdata, exp_data);
    end
    last_exec_addr = fb_waddr;
    if (kind == K_NORM) begin
      @(posedge clk);
      #1;
      check("ready_back", char_ready, 1);
      check("cursor_x", cursor_x, mx);
      check("cursor_y", cursor_y, my);
    end
  endtask

  // Follows a clear or scroll until char_ready returns, checking the write sequence.
  task automatic watch_bulk(input bit scroll, input int exp_first, input string tag);
    int cyc, j, bad, last_w, first_w, ready_cyc;
    int prev_raddr;
    cyc = 0; j = 0; bad = 0; last_w = -1; first_w = -1; ready_cyc = -1;
    prev_raddr = int'(fb_raddr);
    while (cyc < 6000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (fb_we) begin
        if (first_w < 0) first_w = cyc;
        if (!scroll && last_w >= 0 && last_w != cyc - 1) bad++;
        if (scroll && j < CELLS - 80) begin
          if (int'(fb_waddr) != j || int'(fb_waddr) != prev_raddr - 80) bad++;
        end else begin
          if (int'(fb_waddr) != j || fb_wdata !== 8'h20) bad++;
        end
        j++;
        last_w = cyc;
      end
      if (char_ready) begin
        ready_cyc = cyc;
        break;
      end
      prev_raddr = int'(fb_raddr);
    end
    check({tag, "_writes"}, j, CELLS);
    check({tag, "_bad"}, bad, 0);
    check({tag, "_first"}, first_w, exp_first);
    check({tag, "_ready_gap"}, ready_cyc - last_w, 1);
  endtask

  task automatic put(input logic [7:0] b);
    int k;
    send_byte(b, k);
    if (k != K_NORM) begin
      watch_bulk(k == K_SCROLL, 2, (k == K_SCROLL) ? "scroll" : "ff_clear");
      check("bulk_cursor_x", cursor_x, mx);
      check("bulk_cursor_y", cursor_y, my);
    end
  endtask

  task automatic compare_image(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== grid[i]) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    logic [7:0] row1_first;
    logic [7:0] rb;
    int k;
    int r;
    int found;

    // Reset state and power-up clear.
    repeat (3) @(posedge clk);
    #1;
    check("rst_cursor_x", cursor_x, 0);
    check("rst_cursor_y", cursor_y, 0);
    check("rst_we", fb_we, 0);
    check("rst_waddr", fb_waddr, 0);
    check("rst_raddr", fb_raddr, 0);
    check("rst_wdata", fb_wdata, 8'h20);
    check("rst_ready", char_ready, 0);
    check("rst_busy", busy, 1);
    reset = 1'b0;
    model_clear();
    watch_bulk(1'b0, 1, "init_clear");
    check("init_cursor_x", cursor_x, 0);
    check("init_cursor_y", cursor_y, 0);
    compare_image("img_init");

    // Two glyphs.
    put(8'h41);
    put(8'h42);
    check("ab_cursor_x", cursor_x, 2);

    // Full row starting at (0,5).
    put(8'h0D);
    repeat (5) put(8'h0A);
    for (int i = 0; i < 80; i++) put(rand_glyph());
    check("row5_last_addr", last_exec_addr, 479);
    check("row5_cursor_x", cursor_x, 0);
    check("row5_cursor_y", cursor_y, 6);
    compare_image("img_row5");

    // Backspace at column 0, then clear and backspace mid-row on row 2.
    put(8'h08);
    check("bs0_cursor_x", cursor_x, 0);
    check("bs0_cursor_y", cursor_y, 6);
    put(8'h0C);
    put(8'h0A);
    for (int i = 0; i < 12; i++) put(rand_glyph());
    put(8'h0D);
    put(8'h0A);
    repeat (3) put(rand_glyph());
    put(8'h08);
    check("bs3_addr", last_exec_addr, 162);
    check("bs3_cursor_x", cursor_x, 2);
    compare_image("img_bs");

    // Fill the bottom row to force a scroll.
    put(8'h0D);
    while (my != 29) put(8'h0A);
    row1_first = grid[80];
    for (int i = 0; i < 80; i++) put(rand_glyph());
    check("scroll_cursor_x", cursor_x, 0);
    check("scroll_cursor_y", cursor_y, 29);
    check("row1_to_row0", mem[0], row1_first);
    compare_image("img_scroll");

    // Random byte stream.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) rb = 8'h0A;
      else if (r < 14) rb = 8'h0D;
      else if (r < 20) rb = 8'h08;
      else if (r < 21) rb = 8'h0C;
      else rb = 8'($urandom_range(0, 255));
      put(rb);
    end
    compare_image("img_random");

    // Reset in the middle of a scroll copy.
    put(8'h0D);
    while (my != 29) put(8'h0A);
    for (int i = 0; i < 79; i++) put(rand_glyph());
    send_byte(rand_glyph(), k);
    check("mid_kind", k, K_SCROLL);
    found = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (fb_we && fb_waddr == 12'd1000) begin
        found = 1;
        break;
      end
    end
    check("mid_found_copy", found, 1);
    reset = 1'b1;
    char_data = 8'h5A;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_we", fb_we, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_ready", char_ready, 0);
    reset = 1'b0;
    model_clear();
    watch_bulk(1'b0, 1, "rst_clear");
    put(8'h5A);
    check("post_rst_addr", last_exec_addr, 0);
    compare_image("img_post_rst");

    finish_run();
  end

endmodule
